// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM of the multicycle MIPS core (IF/ID/EXE/MEM/WB)
// Ports: clk_i, rst_n_i (sync, active-low); op_i/funct_i from IR; zero_i ALU flag;
// dm_ready_i memory handshake; datapath enables/selects, ext_op_o extender mode,
// dm_rd_o/dm_wr_o memory requests, illegal_o/mem_err_o/instr_done_o one-cycle pulses.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  input  logic       zero_i,
  input  logic       dm_ready_i,
  output logic       pc_wr_o,
  output logic [1:0] pc_src_o,
  output logic       ir_wr_o,
  output logic       gpr_wr_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       alu_srcb_o,
  output logic [1:0] alu_op_o,
  output logic [1:0] ext_op_o,
  output logic       dm_rd_o,
  output logic       dm_wr_o,
  output logic       illegal_o,
  output logic       mem_err_o,
  output logic       instr_done_o
);
  typedef enum logic [2:0] {S_IF, S_ID, S_EXE, S_MEM, S_WB} state_e;
  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic r_type, addu, subu, ori, lui, addiu, lw, sw, beq, j, legal, in_ex, timeout;
  assign r_type  = op_i == 6'b000000;
  assign addu    = r_type && funct_i == 6'b100001;
  assign subu    = r_type && funct_i == 6'b100011;
  assign ori     = op_i == 6'b001101;
  assign lui     = op_i == 6'b001111;
  assign addiu   = op_i == 6'b001001;
  assign lw      = op_i == 6'b100011;
  assign sw      = op_i == 6'b101011;
  assign beq     = op_i == 6'b000100;
  assign j       = op_i == 6'b000010;
  assign legal   = addu | subu | ori | lui | addiu | lw | sw | beq | j;
  // ALU/extender settings are set in EXE and held unchanged through MEM and WB
  assign in_ex   = state_q == S_EXE || state_q == S_MEM || state_q == S_WB;
  // last allowed wait cycle with memory still not ready
  assign timeout = !dm_ready_i && cnt_q == 4'(MEM_TIMEOUT - 1);
  always_comb begin
    state_d      = S_IF;
    cnt_d        = '0;
    pc_wr_o      = 1'b0;
    pc_src_o     = 2'b00;
    ir_wr_o      = 1'b0;
    gpr_wr_o     = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    dm_rd_o      = 1'b0;
    dm_wr_o      = 1'b0;
    illegal_o    = 1'b0;
    mem_err_o    = 1'b0;
    instr_done_o = 1'b0;
    ext_op_o     = !in_ex ? 2'b00 : lui ? 2'b10 : (addiu | lw | sw | beq) ? 2'b01 : 2'b00;
    alu_op_o     = !in_ex ? 2'b00 : (subu | beq) ? 2'b01 : ori ? 2'b10 : 2'b00;
    alu_srcb_o   = in_ex & (ori | lui | addiu | lw | sw);
    case (state_q)
      S_IF: begin
        ir_wr_o = 1'b1;
        pc_wr_o = 1'b1;
        state_d = S_ID;
      end
      S_ID: begin
        pc_wr_o      = j;
        pc_src_o     = j ? 2'b10 : 2'b00;
        illegal_o    = !legal;
        instr_done_o = j | !legal;
        state_d      = (j || !legal) ? S_IF : S_EXE;
      end
      S_EXE: begin
        pc_wr_o      = beq & zero_i;
        pc_src_o     = beq ? 2'b01 : 2'b00;
        instr_done_o = beq;
        state_d      = beq ? S_IF : (lw || sw) ? S_MEM : S_WB;
      end
      S_MEM: begin
        dm_rd_o      = lw;
        dm_wr_o      = sw;
        mem_err_o    = timeout;
        instr_done_o = (dm_ready_i & sw) | timeout;
        cnt_d        = (dm_ready_i || timeout) ? 4'd0 : cnt_q + 4'd1;
        state_d      = (dm_ready_i && lw) ? S_WB : (dm_ready_i || timeout) ? S_IF : S_MEM;
      end
      S_WB: begin
        gpr_wr_o     = 1'b1;
        reg_dst_o    = r_type;
        mem_to_reg_o = lw;
        instr_done_o = 1'b1;
      end
      default: state_d = S_IF;
    endcase
    if (!rst_n_i) begin
      {pc_wr_o, pc_src_o, ir_wr_o, gpr_wr_o, reg_dst_o, mem_to_reg_o, alu_srcb_o} = '0;
      {alu_op_o, ext_op_o, dm_rd_o, dm_wr_o, illegal_o, mem_err_o, instr_done_o} = '0;
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= S_IF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: randomized instruction streams checked against a per-instruction cycle trace model
module tb_multicycle_ctrl;
  localparam int TO = 15;
  typedef struct packed {
    logic       pc_wr;
    logic [1:0] pc_src;
    logic       ir_wr;
    logic       gpr_wr;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_srcb;
    logic [1:0] alu_op;
    logic [1:0] ext_op;
    logic       dm_rd;
    logic       dm_wr;
    logic       illegal;
    logic       mem_err;
    logic       instr_done;
  } ctl_t;
  logic clk = 1'b0, rst_n = 1'b0, zero = 1'b0, dm_ready = 1'b0;
  logic [5:0] op = '0, funct = '0;
  logic pc_wr, ir_wr, gpr_wr, reg_dst, mem_to_reg, alu_srcb, dm_rd, dm_wr, illegal, mem_err, instr_done;
  logic [1:0] pc_src, alu_op, ext_op;
  ctl_t obs;
  ctl_t exp_q[$];
  logic rdy_q[$];
  string tag_q[$];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .op_i(op), .funct_i(funct), .zero_i(zero), .dm_ready_i(dm_ready),
    .pc_wr_o(pc_wr), .pc_src_o(pc_src), .ir_wr_o(ir_wr), .gpr_wr_o(gpr_wr), .reg_dst_o(reg_dst),
    .mem_to_reg_o(mem_to_reg), .alu_srcb_o(alu_srcb), .alu_op_o(alu_op), .ext_op_o(ext_op),
    .dm_rd_o(dm_rd), .dm_wr_o(dm_wr), .illegal_o(illegal), .mem_err_o(mem_err), .instr_done_o(instr_done)
  );
  assign obs = {pc_wr, pc_src, ir_wr, gpr_wr, reg_dst, mem_to_reg, alu_srcb, alu_op, ext_op,
                dm_rd, dm_wr, illegal, mem_err, instr_done};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic void push(input ctl_t c, input logic rdy, input string tag);
    exp_q.push_back(c);
    rdy_q.push_back(rdy);
    tag_q.push_back(tag);
  endfunction
  // Expected per-cycle controls of one instruction; waits = MEM cycles before dm_ready rises
  function automatic void build(input logic [5:0] o, input logic [5:0] f, input logic z, input int waits);
    logic r, addu, subu, ori, lui, addiu, lw, sw, beq, j, ok, rdy;
    ctl_t c, ex;
    r = o == 6'h00; addu = r && f == 6'h21; subu = r && f == 6'h23;
    ori = o == 6'h0d; lui = o == 6'h0f; addiu = o == 6'h09; lw = o == 6'h23;
    sw = o == 6'h2b; beq = o == 6'h04; j = o == 6'h02;
    ok = addu | subu | ori | lui | addiu | lw | sw | beq | j;
    c = '0; c.ir_wr = 1; c.pc_wr = 1;
    push(c, 1'($urandom), "if");
    c = '0;
    if (j) begin c.pc_wr = 1; c.pc_src = 2'b10; c.instr_done = 1; end
    if (!ok) begin c.illegal = 1; c.instr_done = 1; end
    push(c, 1'($urandom), "id");
    if (j || !ok) return;
    ex = '0;
    ex.ext_op = lui ? 2'b10 : (addiu | lw | sw | beq) ? 2'b01 : 2'b00;
    ex.alu_op = (subu | beq) ? 2'b01 : ori ? 2'b10 : 2'b00;
    ex.alu_srcb = ori | lui | addiu | lw | sw;
    c = ex;
    if (beq) begin c.pc_wr = z; c.pc_src = 2'b01; c.instr_done = 1; end
    push(c, 1'($urandom), "exe");
    if (beq) return;
    if (lw || sw) begin
      for (int k = 0; k < TO; k++) begin
        c = ex; c.dm_rd = lw; c.dm_wr = sw;
        rdy = k == waits;
        if (!rdy && k == TO - 1) begin
          c.mem_err = 1; c.instr_done = 1;
          push(c, 1'b0, "mem_to");
          return;
        end
        if (rdy && sw) c.instr_done = 1;
        push(c, rdy, "mem");
        if (rdy) break;
      end
      if (sw) return;
    end
    c = ex; c.gpr_wr = 1; c.reg_dst = r; c.mem_to_reg = lw; c.instr_done = 1;
    push(c, 1'($urandom), "wb");
  endfunction
  task automatic run(input logic [5:0] o, input logic [5:0] f, input logic z, input int waits, input int abort_at);
    build(o, f, z, waits);
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(negedge clk);
      rst_n = 1'b1; op = o; funct = f; zero = z; dm_ready = rdy_q.pop_front();
      if (i == abort_at) begin
        rst_n = 1'b0;
        #1 chk("rst_mid", obs, '0);
        exp_q.delete(); rdy_q.delete(); tag_q.delete();
      end else begin
        #1 chk(tag_q.pop_front(), obs, exp_q.pop_front());
      end
    end
  endtask
  initial begin
    logic [5:0] ops[9];
    logic [5:0] o, f;
    int w, ab;
    ops = '{6'h00, 6'h00, 6'h0d, 6'h0f, 6'h09, 6'h23, 6'h2b, 6'h04, 6'h02};
    op = 6'h23;
    repeat (3) begin
      @(negedge clk);
      dm_ready = 1'($urandom);
      #1 chk("reset", obs, '0);
    end
    run(6'h0d, 6'h00, 0, 0, -1);
    run(6'h0f, 6'h15, 0, 0, -1);
    run(6'h09, 6'h00, 1, 0, -1);
    run(6'h23, 6'h00, 0, 2, -1);
    run(6'h04, 6'h00, 1, 0, -1);
    run(6'h04, 6'h00, 0, 0, -1);
    run(6'h02, 6'h00, 0, 0, -1);
    run(6'h3f, 6'h00, 0, 0, -1);
    run(6'h2b, 6'h00, 0, 20, -1);
    run(6'h2b, 6'h00, 0, TO - 1, -1);
    run(6'h23, 6'h00, 0, 5, 4);
    run(6'h00, 6'h21, 0, 0, -1);
    run(6'h00, 6'h23, 0, 0, -1);
    run(6'h00, 6'h20, 0, 0, -1);
    for (int n = 0; n < 300; n++) begin
      int k;
      k = $urandom_range(0, 9);
      if (k == 9) begin
        o = 6'($urandom); f = 6'($urandom);
      end else begin
        o = ops[k];
        f = k == 0 ? 6'h21 : k == 1 ? 6'h23 : 6'($urandom);
      end
      w = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 2, TO + 2) : $urandom_range(0, 3);
      ab = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 5) : -1;
      run(o, f, 1'($urandom), w, ab);
    end
    run(6'h02, 6'h00, 0, 0, -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
